// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared register-file constants for the single-cycle CPU
package reg_file_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP = 5'd29;
    localparam logic [4:0] REG_RA = 5'd31;
    localparam logic [31:0] SP_INIT = 32'h0000_0000;
endpackage

// File: rtl/reg_file_rport.sv
// reg_file_rport: one combinational read port with $zero forcing and write-through bypass
module reg_file_rport
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] regs [0:2**ADDR_W-1],
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rdata
);
    assign rdata = (raddr == ADDR_W'(REG_ZERO)) ? '0 : (we && wa == raddr) ? wd : regs[raddr];
endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, $zero hardwired, bypassed read ports, unbypassed debug port
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] SP_INIT_V = DATA_W'(SP_INIT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              stall,
    input  logic [ADDR_W-1:0] dbg_a,
    output logic [DATA_W-1:0] dbg_d
);
    localparam int NREG = 2**ADDR_W;
    logic [DATA_W-1:0] regs [0:NREG-1];
    logic wen;
    assign wen = we && !stall && !rst;
    // committed storage: async clear to reset values, writes to $zero dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (i == int'(REG_SP)) ? SP_INIT_V : '0;
        end else if (wen && wa != ADDR_W'(REG_ZERO)) begin
            regs[wa] <= wd;
        end
    end
    reg_file_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp1 (
        .raddr(ra1), .regs(regs), .we(wen), .wa(wa), .wd(wd), .rdata(rd1)
    );
    reg_file_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp2 (
        .raddr(ra2), .regs(regs), .we(wen), .wa(wa), .wd(wd), .rdata(rd2)
    );
    assign dbg_d = (dbg_a == ADDR_W'(REG_ZERO)) ? '0 : regs[dbg_a];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scoreboard bench for reg_file
module tb_reg_file;
    import reg_file_pkg::*;
    logic clk = 0, rst = 0, we = 0, stall = 0;
    logic [4:0] ra1 = 0, ra2 = 0, wa = 0, dbg_a = 0;
    logic [31:0] wd = 0;
    logic [31:0] rd1, rd2, dbg_d;
    int checks = 0, errors = 0;
    typedef struct {
        int sel;
        logic [31:0] exp;
        string name;
    } chk_t;
    chk_t q[$];
    event go;

    reg_file dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd), .stall(stall), .dbg_a(dbg_a), .dbg_d(dbg_d)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(go);
            while (q.size() > 0) begin
                chk_t c;
                logic [31:0] act;
                c = q.pop_front();
                act = (c.sel == 0) ? rd1 : (c.sel == 1) ? rd2 : dbg_d;
                checks++;
                if (act !== c.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
                end
            end
        end
    end

    task automatic expect_out(input int sel, input logic [31:0] exp, input string name);
        chk_t c;
        c.sel = sel;
        c.exp = exp;
        c.name = name;
        q.push_back(c);
    endtask

    task automatic settle();
        #1;
        -> go;
        for (int k = 0; k < 10 && q.size() > 0; k++) #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL monitor_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1; wa = a; wd = d;
        @(negedge clk);
        we = 0;
    endtask

    initial begin
        // 1: async reset with random inputs, then full dump of committed state
        #2;
        rst = 1; we = 1; wa = 5'($urandom); wd = $urandom; ra1 = 29; ra2 = 5;
        expect_out(0, SP_INIT, "rst_rd1_sp");
        expect_out(1, 32'h0, "rst_rd2_r5");
        settle();
        @(negedge clk);
        @(negedge clk);
        rst = 0; we = 0;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            dbg_a = 5'(i);
            expect_out(2, (i == 29) ? SP_INIT : 32'h0, $sformatf("rst_dbg_%0d", i));
            settle();
        end
        // 2: write then read back
        wr(5'd8, 32'hDEAD_BEEF);
        ra1 = 8; dbg_a = 8;
        expect_out(0, 32'hDEAD_BEEF, "wr_rd1_r8");
        expect_out(2, 32'hDEAD_BEEF, "wr_dbg_r8");
        settle();
        // 3: writes to $zero are dropped
        @(negedge clk);
        we = 1; wa = 0; wd = 32'hFFFF_FFFF; ra1 = 0; dbg_a = 0;
        expect_out(0, 32'h0, "zero_rd1_same");
        settle();
        @(negedge clk);
        we = 0;
        expect_out(0, 32'h0, "zero_rd1_next");
        expect_out(2, 32'h0, "zero_dbg");
        settle();
        // 4: bypass on both ports, debug shows committed value
        wr(5'd3, 32'h1);
        we = 1; wa = 3; wd = 32'h55; ra1 = 3; ra2 = 3; dbg_a = 3;
        expect_out(0, 32'h55, "byp_rd1");
        expect_out(1, 32'h55, "byp_rd2");
        expect_out(2, 32'h1, "byp_dbg_before");
        settle();
        @(negedge clk);
        we = 0;
        expect_out(2, 32'h55, "byp_dbg_after");
        settle();
        // 5: stall blocks both bypass and write
        wr(5'd4, 32'h7);
        stall = 1; we = 1; wa = 4; wd = 32'h9; ra1 = 4; ra2 = 8;
        expect_out(0, 32'h7, "stall_rd1");
        expect_out(1, 32'hDEAD_BEEF, "stall_rd2_r8");
        settle();
        @(negedge clk);
        stall = 0; we = 0; dbg_a = 4;
        expect_out(2, 32'h7, "stall_dbg_r4");
        settle();
        // 6: async reset between edges kills pending write
        wr(5'd10, 32'hA5);
        we = 1; wa = 10; wd = 32'h3C; ra1 = 10; ra2 = 9; dbg_a = 10;
        expect_out(0, 32'h3C, "pre_rst_bypass");
        expect_out(1, 32'h0, "pre_rst_rd2_r9");
        expect_out(2, 32'hA5, "pre_rst_dbg");
        settle();
        rst = 1;
        expect_out(0, 32'h0, "mid_rst_rd1");
        expect_out(2, 32'h0, "mid_rst_dbg");
        settle();
        @(negedge clk);
        rst = 0; we = 0;
        @(negedge clk);
        expect_out(2, 32'h0, "post_rst_dbg_r10");
        ra1 = 8;
        expect_out(0, 32'h0, "post_rst_rd1_r8");
        settle();
        // first write after release lands at the next edge
        wr(5'd10, 32'h77);
        expect_out(2, 32'h77, "post_rst_write");
        settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end
endmodule
